// File: rtl/sched_in_arbiter_pkg.sv
// Shared types, constants and the cyclic round-robin helper for sched_in_arbiter.
package sched_in_arbiter_pkg;

  localparam int ARB_CNT_WIDTH = 32;
  localparam int MAX_SLAVES    = 4;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  // Lowest set index at or after ptr, wrapping modulo MAX_SLAVES; returns ptr when none is set.
  function automatic logic [1:0] rr_next(input logic [MAX_SLAVES-1:0] valid,
                                         input logic [1:0]            ptr);
    logic [1:0] idx;
    rr_next = ptr;
    for (int k = MAX_SLAVES - 1; k >= 0; k--) begin
      idx = ptr + 2'(k);
      if (valid[idx]) rr_next = idx;
    end
  endfunction

endpackage

// File: rtl/sched_in_rr_pick.sv
// Combinational round-robin selector: valid vector and start pointer in, winner index and any-valid out.
module sched_in_rr_pick
  import sched_in_arbiter_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] i_valid,
  input  logic [1:0]   i_ptr,
  output logic [1:0]   o_idx,
  output logic         o_any
);

  logic [MAX_SLAVES-1:0] w_valid;

  assign w_valid = MAX_SLAVES'(i_valid);
  assign o_idx   = rr_next(w_valid, i_ptr);
  assign o_any   = |i_valid;

endmodule

// File: rtl/sched_in_arbiter.sv
// Packet-atomic round-robin arbiter feeding the scheduler new-task stream through one output register.
// Per-source packet counters are built only when SCHED_IN_ARBITER_STATS_EN is defined.
module sched_in_arbiter
  import sched_in_arbiter_pkg::*;
#(
  parameter int NSLAVES    = 2,
  parameter int ID_WIDTH   = 8,
  parameter int DATA_WIDTH = 64
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic [NSLAVES-1:0]               s_valid,
  output logic [NSLAVES-1:0]               s_ready,
  input  logic [NSLAVES*DATA_WIDTH-1:0]    s_data,
  input  logic [NSLAVES*ID_WIDTH-1:0]      s_id,
  input  logic [NSLAVES-1:0]               s_last,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic [ID_WIDTH-1:0]              m_id,
  output logic                             m_last,
  output logic [1:0]                       grant,
  output logic                             busy,
  output logic [NSLAVES*ARB_CNT_WIDTH-1:0] pkt_count
);

  // Handshake: a beat moves on s_valid[i] && s_ready[i] at the rising edge, and on m_valid && m_ready
  // at the output; once m_valid is high it and m_* hold until m_ready.
  arb_state_e            r_state;
  arb_state_e            w_next_state;
  logic [1:0]            r_grant;
  logic [1:0]            r_rr_ptr;
  logic [1:0]            w_pick;
  logic                  w_any;
  logic [MAX_SLAVES-1:0] w_valid_pad;
  logic [MAX_SLAVES-1:0] w_last_pad;
  logic                  w_can_load;
  logic                  w_accept;
  logic                  w_last_beat;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic [ID_WIDTH-1:0]   w_sel_id;
  logic                  r_m_valid;
  logic                  r_m_last;
  logic [DATA_WIDTH-1:0] r_m_data;
  logic [ID_WIDTH-1:0]   r_m_id;

  sched_in_rr_pick #(.N(NSLAVES)) u_pick (
    .i_valid (s_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick),
    .o_any   (w_any)
  );

  assign w_valid_pad = MAX_SLAVES'(s_valid);
  assign w_last_pad  = MAX_SLAVES'(s_last);
  assign w_can_load  = !r_m_valid || m_ready;
  assign w_last_beat = w_accept && w_last_pad[r_grant];

  always_comb begin
    w_sel_data = '0;
    w_sel_id   = '0;
    for (int i = 0; i < NSLAVES; i++) begin
      if (r_grant == 2'(i)) begin
        w_sel_data = s_data[DATA_WIDTH*i +: DATA_WIDTH];
        w_sel_id   = s_id[ID_WIDTH*i +: ID_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next_state;
  end

  // Only the owning source ever sees s_ready; all others wait until its last beat.
  always_comb begin
    w_next_state = r_state;
    s_ready      = '0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any) w_next_state = LOCKED;
      end
      LOCKED: begin
        for (int i = 0; i < NSLAVES; i++) begin
          if (r_grant == 2'(i)) s_ready[i] = w_can_load;
        end
        w_accept = w_valid_pad[r_grant] && w_can_load;
        if (w_accept && w_last_pad[r_grant]) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_grant  <= 2'd0;
      r_rr_ptr <= 2'd0;
    end else begin
      if (r_state == IDLE && w_any) r_grant <= w_pick;
      if (w_last_beat) r_rr_ptr <= (r_grant == 2'(NSLAVES - 1)) ? 2'd0 : r_grant + 2'd1;
    end
  end

  // A load in the same cycle as a drain keeps m_valid high with the new beat.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
      r_m_id    <= '0;
    end else if (w_accept) begin
      r_m_valid <= 1'b1;
      r_m_last  <= w_last_pad[r_grant];
      r_m_data  <= w_sel_data;
      r_m_id    <= w_sel_id;
    end else if (m_ready) begin
      r_m_valid <= 1'b0;
    end
  end

  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign m_data  = r_m_data;
  assign m_id    = r_m_id;
  assign grant   = r_grant;
  assign busy    = (r_state == LOCKED);

`ifdef SCHED_IN_ARBITER_STATS_EN
  for (genvar gi = 0; gi < NSLAVES; gi++) begin : g_cnt
    logic [ARB_CNT_WIDTH-1:0] r_cnt;
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                                  r_cnt <= '0;
      else if (w_last_beat && r_grant == 2'(gi))  r_cnt <= r_cnt + 1'b1;
    end
    assign pkt_count[ARB_CNT_WIDTH*gi +: ARB_CNT_WIDTH] = r_cnt;
  end
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_sched_in_arbiter.sv
// Directed testbench for sched_in_arbiter with NSLAVES=2; also covers SCHED_IN_ARBITER_STATS_EN when defined.
module tb_sched_in_arbiter;

`ifdef SCHED_IN_ARBITER_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rstn;
  logic [1:0]   s_valid;
  logic [1:0]   s_ready;
  logic [127:0] s_data;
  logic [15:0]  s_id;
  logic [1:0]   s_last;
  logic         m_valid;
  logic         m_ready;
  logic [63:0]  m_data;
  logic [7:0]   m_id;
  logic         m_last;
  logic [1:0]   grant;
  logic         busy;
  logic [63:0]  pkt_count;

  int           checks = 0;
  int           failures = 0;
  logic [63:0]  exp_q[$];

  logic [63:0]  src_base[2];
  int           src_len[2];
  int           src_beat[2];
  int           src_lim[2];
  logic         src_hold[2];

  sched_in_arbiter #(.NSLAVES(2), .ID_WIDTH(8), .DATA_WIDTH(64)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_id      (s_id),
    .s_last    (s_last),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_id      (m_id),
    .m_last    (m_last),
    .grant     (grant),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drivers: each source streams base+beat, tlast every len beats, stopping at lim beats.
  task automatic drive_srcs();
    for (int i = 0; i < 2; i++) begin
      s_valid[i]         = (src_beat[i] < src_lim[i]) && !src_hold[i];
      s_data[64*i +: 64] = src_base[i] + 64'(src_beat[i]);
      s_id[8*i +: 8]     = 8'hA0 + 8'(i);
      s_last[i]          = ((src_beat[i] % src_len[i]) == src_len[i] - 1);
    end
  endtask

  task automatic src_cfg(input int i, input logic [63:0] base, input int len, input int lim);
    src_base[i] = base;
    src_len[i]  = len;
    src_beat[i] = 0;
    src_lim[i]  = lim;
    src_hold[i] = 1'b0;
  endtask

  // One clock: scoreboard the output handshake, advance accepted sources, redrive at negedge.
  task automatic tick();
    logic [1:0]  acc;
    logic [63:0] e;
    acc = s_valid & s_ready;
    if (m_valid && m_ready) begin
      chk("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("sb_data", m_data, e);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 2; i++) if (acc[i]) src_beat[i]++;
    drive_srcs();
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) src_cfg(i, 64'h0, 1, 0);
    exp_q.delete();
    drive_srcs();
    @(negedge clk);
    rstn = 1'b1;
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
    chk({tag, "_m_last"},  64'(m_last),  64'd0);
    chk({tag, "_m_data"},  m_data,       64'd0);
    chk({tag, "_m_id"},    64'(m_id),    64'd0);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
    chk({tag, "_grant"},   64'(grant),   64'd0);
    chk({tag, "_busy"},    64'(busy),    64'd0);
    chk({tag, "_pkt"},     pkt_count,    64'd0);
  endtask

  initial begin
    rstn    = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 2; i++) src_cfg(i, 64'h0, 1, 0);
    drive_srcs();
    @(negedge clk);
    #1;
    chk_reset_vals("rst");
    @(negedge clk);
    rstn = 1'b1;
    #1;

    // Single 3-beat packet from src0
    src_cfg(0, 64'h10, 3, 3);
    exp_q.push_back(64'h10); exp_q.push_back(64'h11); exp_q.push_back(64'h12);
    drive_srcs(); #1;
    tick();
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_grant", 64'(grant), 64'd0);
    chk("t1_sready", 64'(s_ready), 64'd1);
    chk("t1_mvalid0", 64'(m_valid), 64'd0);
    tick();
    chk("t1_mvalid1", 64'(m_valid), 64'd1);
    chk("t1_d0", m_data, 64'h10);
    chk("t1_id", 64'(m_id), 64'hA0);
    chk("t1_last0", 64'(m_last), 64'd0);
    tick();
    chk("t1_d1", m_data, 64'h11);
    tick();
    chk("t1_d2", m_data, 64'h12);
    chk("t1_last2", 64'(m_last), 64'd1);
    chk("t1_idle", 64'(busy), 64'd0);
    chk("t1_sready_idle", 64'(s_ready), 64'd0);
    tick();
    chk("t1_drained", 64'(m_valid), 64'd0);
    chk("t1_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t1_pkt", pkt_count, STATS_ON ? 64'h1 : 64'h0);

    // Both sources continuously valid, 2-beat packets, starting from rr_ptr=0
    do_reset();
    src_cfg(0, 64'h20, 2, 4);
    src_cfg(1, 64'h30, 2, 4);
    exp_q.push_back(64'h20); exp_q.push_back(64'h21);
    exp_q.push_back(64'h30); exp_q.push_back(64'h31);
    exp_q.push_back(64'h22); exp_q.push_back(64'h23);
    exp_q.push_back(64'h32); exp_q.push_back(64'h33);
    drive_srcs(); #1;
    tick(); chk("t2_g0a", 64'(grant), 64'd0);
    tick(); chk("t2_d20", m_data, 64'h20);
    tick(); chk("t2_bubble1", 64'(busy), 64'd0);
    tick(); chk("t2_g1a", 64'(grant), 64'd1);
            chk("t2_sready1", 64'(s_ready), 64'd2);
    tick(); chk("t2_id1", 64'(m_id), 64'hA1);
    tick(); chk("t2_bubble2", 64'(busy), 64'd0);
    tick(); chk("t2_g0b", 64'(grant), 64'd0);
    tick(); tick(); chk("t2_bubble3", 64'(busy), 64'd0);
    tick(); chk("t2_g1b", 64'(grant), 64'd1);
    tick(); tick(); tick();
    chk("t2_done", 64'(m_valid), 64'd0);
    chk("t2_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t2_pkt", pkt_count, STATS_ON ? 64'h0000_0002_0000_0002 : 64'h0);

    // m_ready held low for 5 cycles mid-packet
    do_reset();
    src_cfg(0, 64'h40, 4, 4);
    for (int k = 0; k < 4; k++) exp_q.push_back(64'h40 + 64'(k));
    drive_srcs(); #1;
    tick(); tick();
    chk("t3_d40", m_data, 64'h40);
    m_ready = 1'b0; #1;
    chk("t3_sready_low", 64'(s_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_data", m_data, 64'h40);
      chk("t3_hold_valid", 64'(m_valid), 64'd1);
      chk("t3_hold_sready", 64'(s_ready), 64'd0);
    end
    m_ready = 1'b1; #1;
    chk("t3_sready_back", 64'(s_ready), 64'd1);
    tick(); chk("t3_d41", m_data, 64'h41);
    tick(); tick(); chk("t3_last", 64'(m_last), 64'd1);
    tick();
    chk("t3_sb_empty", 64'(exp_q.size()), 64'd0);

    // src1 stalls mid-packet while src0 waits
    do_reset();
    src_cfg(0, 64'h50, 1, 2);
    exp_q.push_back(64'h50);
    drive_srcs(); #1;
    tick(); tick();
    src_cfg(1, 64'h60, 4, 4);
    for (int k = 0; k < 4; k++) exp_q.push_back(64'h60 + 64'(k));
    exp_q.push_back(64'h51);
    drive_srcs(); #1;
    tick(); chk("t4_grant1", 64'(grant), 64'd1);
    tick(); chk("t4_d60", m_data, 64'h60);
    src_hold[1] = 1'b1;
    drive_srcs(); #1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_stall_grant", 64'(grant), 64'd1);
      chk("t4_stall_busy", 64'(busy), 64'd1);
      chk("t4_stall_sready", 64'(s_ready), 64'd2);
    end
    src_hold[1] = 1'b0;
    drive_srcs(); #1;
    tick(); chk("t4_d61", m_data, 64'h61);
    tick(); tick(); chk("t4_last63", 64'(m_last), 64'd1);
    tick(); chk("t4_grant0", 64'(grant), 64'd0);
    tick(); chk("t4_d51", m_data, 64'h51);
    tick();
    chk("t4_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t4_pkt", pkt_count, STATS_ON ? 64'h0000_0001_0000_0002 : 64'h0);

    // Reset during beat 2 of a 4-beat packet while rr_ptr=1
    src_cfg(1, 64'h70, 4, 4);
    exp_q.push_back(64'h70); exp_q.push_back(64'h71);
    drive_srcs(); #1;
    tick(); chk("t5_grant1", 64'(grant), 64'd1);
    tick(); tick();
    chk("t5_d71", m_data, 64'h71);
    rstn = 1'b0;
    #1;
    chk_reset_vals("t5_rst");
    exp_q.delete();
    for (int i = 0; i < 2; i++) src_cfg(i, 64'h0, 1, 0);
    drive_srcs();
    @(negedge clk);
    rstn = 1'b1;
    src_cfg(0, 64'h80, 1, 1);
    src_cfg(1, 64'h90, 1, 1);
    exp_q.push_back(64'h80); exp_q.push_back(64'h90);
    drive_srcs(); #1;
    tick(); chk("t5_grant_after_rst", 64'(grant), 64'd0);
    tick(); chk("t5_d80", m_data, 64'h80);
    tick(); chk("t5_grant_next", 64'(grant), 64'd1);
    tick(); chk("t5_d90", m_data, 64'h90);
    tick();
    chk("t5_sb_empty", 64'(exp_q.size()), 64'd0);
    chk("t5_pkt", pkt_count, STATS_ON ? 64'h0000_0001_0000_0001 : 64'h0);

`ifdef SCHED_IN_ARBITER_STATS_EN
    // Counter wrap from 0xFFFFFFFF
    do_reset();
    force dut.g_cnt[0].r_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.g_cnt[0].r_cnt;
    #1;
    chk("t6_preload", pkt_count, 64'h0000_0000_FFFF_FFFF);
    src_cfg(0, 64'hB0, 1, 1);
    exp_q.push_back(64'hB0);
    drive_srcs(); #1;
    tick(); tick(); tick();
    chk("t6_wrap", pkt_count, 64'h0);
    chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
